// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, writeback
// select encodings, the memory FSM states and the MEM/WB register layout.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rsw;
    logic [31:0] inst;
  } mem_wb_t;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) & off[0]) | ((f3[1:0] == 2'b10) & (|off));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte enables and load extraction.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        rw_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    wdata_o = rs2_i;
    be_o    = 4'b1111;
    if (rw_i) begin
      case (funct3_i)
        F3_B: begin
          wdata_o = {4{rs2_i[7:0]}};
          be_o    = 4'b0001 << off_i;
        end
        F3_H: begin
          wdata_o = {2{rs2_i[15:0]}};
          be_o    = 4'b0011 << {off_i[1], 1'b0};
        end
        default: begin
          wdata_o = rs2_i;
          be_o    = 4'b1111;
        end
      endcase
    end else begin
      wdata_o = rs2_i;
      be_o    = 4'b1111;
    end
  end

  always_comb begin
    w_byte = rdata_i[{off_i, 3'b000} +: 8];
    w_half = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_o = {24'h000000, w_byte};
      F3_H:    load_o = {{16{w_half[15]}}, w_half};
      F3_HU:   load_o = {16'h0000, w_half};
      F3_W:    load_o = rdata_i;
      default: load_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: cache valid/ready handshake FSM, returned-data buffer
// for frozen pipelines, and the MEM/WB pipeline register.
module mem_stage
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_mem_i,
  input  logic [31:0] rs2_mem_i,
  input  logic [31:0] pc4_mem_i,
  input  logic        MemRW_mem_i,
  input  logic [1:0]  WBSel_mem_i,
  input  logic        RegWEn_mem_i,
  input  logic [4:0]  rsW_mem_i,
  input  logic [31:0] inst_mem_i,
  input  logic        Valid_cpu2cache_mem_i,
  input  logic        enable_i,
  input  logic        reset_i,
  output logic [31:0] addr_cache_o,
  output logic [31:0] wdata_cache_o,
  output logic [3:0]  be_cache_o,
  output logic        rw_cache_o,
  output logic        valid_cache_o,
  input  logic        ready_cache_i,
  input  logic [31:0] rdata_cache_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] alu_wb_o,
  output logic [31:0] mem_wb_o,
  output logic [31:0] pc4_wb_o,
  output logic [1:0]  WBSel_wb_o,
  output logic        RegWEn_wb_o,
  output logic [4:0]  rsW_wb_o,
  output logic [31:0] inst_wb_o
);

  mem_state_e  r_state;
  mem_state_e  w_state_raw;
  mem_state_e  w_state_nxt;
  mem_wb_t     r_wb;
  logic [31:0] r_buf;
  logic [31:0] w_load;
  logic [31:0] w_mem_nxt;
  logic [2:0]  w_funct3;
  logic        w_ack;
  logic        w_advance;
  logic        w_flush;

  assign w_funct3     = inst_mem_i[14:12];
  assign addr_cache_o = alu_mem_i;
  assign rw_cache_o   = MemRW_mem_i;

  lsu_align u_align (
    .funct3_i (w_funct3),
    .off_i    (alu_mem_i[1:0]),
    .rw_i     (MemRW_mem_i),
    .rs2_i    (rs2_mem_i),
    .rdata_i  (rdata_cache_i),
    .wdata_o  (wdata_cache_o),
    .be_o     (be_cache_o),
    .load_o   (w_load)
  );

  // Gated by rst_i so the handshake is quiet the moment reset asserts
  assign misalign_o    = ~rst_i & Valid_cpu2cache_mem_i & is_misaligned(w_funct3, alu_mem_i[1:0]);
  assign valid_cache_o = ~rst_i & ((r_state == WAIT) |
                         (Valid_cpu2cache_mem_i & ~misalign_o & (r_state == IDLE)));
  assign w_ack         = valid_cache_o & ready_cache_i;
  assign stall_o       = valid_cache_o & ~ready_cache_i;
  assign w_advance     = enable_i & ~stall_o;
  assign w_flush       = w_advance & reset_i & (r_state != WAIT);
  assign w_state_nxt   = w_flush ? IDLE : w_state_raw;

  // Next-state logic for the cache handshake
  always_comb begin
    w_state_raw = r_state;
    case (r_state)
      IDLE: begin
        if (stall_o) begin
          w_state_raw = WAIT;
        end else if (w_ack & ~enable_i) begin
          w_state_raw = DONE;
        end else begin
          w_state_raw = IDLE;
        end
      end
      WAIT: begin
        if (ready_cache_i) begin
          w_state_raw = enable_i ? IDLE : DONE;
        end else begin
          w_state_raw = WAIT;
        end
      end
      DONE: begin
        w_state_raw = enable_i ? IDLE : DONE;
      end
      default: w_state_raw = IDLE;
    endcase
  end

  // Buffered data wins in DONE; misaligned and non-memory results are zero
  always_comb begin
    if (r_state == DONE) begin
      w_mem_nxt = r_buf;
    end else if (w_ack) begin
      w_mem_nxt = w_load;
    end else begin
      w_mem_nxt = 32'h0000_0000;
    end
  end

  // FSM state and returned-data buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_buf   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_ack) begin
        r_buf <= w_load;
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb <= '0;
    end else if (w_flush) begin
      r_wb <= '0;
    end else if (w_advance) begin
      r_wb.alu    <= alu_mem_i;
      r_wb.mem    <= w_mem_nxt;
      r_wb.pc4    <= pc4_mem_i;
      r_wb.wbsel  <= WBSel_mem_i;
      r_wb.regwen <= RegWEn_mem_i;
      r_wb.rsw    <= rsW_mem_i;
      r_wb.inst   <= inst_mem_i;
    end
  end

  assign alu_wb_o    = r_wb.alu;
  assign mem_wb_o    = r_wb.mem;
  assign pc4_wb_o    = r_wb.pc4;
  assign WBSel_wb_o  = r_wb.wbsel;
  assign RegWEn_wb_o = r_wb.regwen;
  assign rsW_wb_o    = r_wb.rsw;
  assign inst_wb_o   = r_wb.inst;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver pushes expected MEM/WB contents,
// a monitor pops and compares them after every edge the pipeline advances.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] alu_mem_i, rs2_mem_i, pc4_mem_i, inst_mem_i, rdata_cache_i;
  logic        MemRW_mem_i, RegWEn_mem_i, Valid_cpu2cache_mem_i, enable_i, reset_i, ready_cache_i;
  logic [1:0]  WBSel_mem_i;
  logic [4:0]  rsW_mem_i;
  logic [31:0] addr_cache_o, wdata_cache_o, alu_wb_o, mem_wb_o, pc4_wb_o, inst_wb_o;
  logic [3:0]  be_cache_o;
  logic        rw_cache_o, valid_cache_o, stall_o, misalign_o, RegWEn_wb_o;
  logic [1:0]  WBSel_wb_o;
  logic [4:0]  rsW_wb_o;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i),
    .pc4_mem_i(pc4_mem_i), .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i),
    .RegWEn_mem_i(RegWEn_mem_i), .rsW_mem_i(rsW_mem_i), .inst_mem_i(inst_mem_i),
    .Valid_cpu2cache_mem_i(Valid_cpu2cache_mem_i), .enable_i(enable_i), .reset_i(reset_i),
    .addr_cache_o(addr_cache_o), .wdata_cache_o(wdata_cache_o), .be_cache_o(be_cache_o),
    .rw_cache_o(rw_cache_o), .valid_cache_o(valid_cache_o), .ready_cache_i(ready_cache_i),
    .rdata_cache_i(rdata_cache_i), .stall_o(stall_o), .misalign_o(misalign_o),
    .alu_wb_o(alu_wb_o), .mem_wb_o(mem_wb_o), .pc4_wb_o(pc4_wb_o), .WBSel_wb_o(WBSel_wb_o),
    .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o), .inst_wb_o(inst_wb_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] alu, mem, pc4, inst;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rsw;
  } wb_t;

  wb_t  exp_q[$];
  logic exp_adv = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off, b, h;
    off = addr % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return rd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    sz = f3 % 4;
    return ((sz == 1) && (addr % 2 != 0)) || ((sz == 2) && (addr % 4 != 0));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3 == 3'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
    else if (f3 == 3'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    else return rs2;
  endfunction

  function automatic logic [31:0] ref_be(input logic rw, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (!rw) return 32'hF;
    else if (f3 == 3'd0) return 32'd1 << off;
    else if (f3 == 3'd1) return (off >= 2) ? 32'hC : 32'h3;
    else return 32'hF;
  endfunction

  task automatic req_checks(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic exp_stall);
    check("valid_req", valid_cache_o, 32'd1);
    check("stall", stall_o, {31'd0, exp_stall});
    check("addr", addr_cache_o, addr);
    check("rw", rw_cache_o, {31'd0, rw});
    check("be", be_cache_o, ref_be(rw, f3, addr));
    if (rw) check("wdata", wdata_cache_o, ref_wdata(f3, rs2));
  endtask

  // One instruction through the stage: lat cycles of miss, then hold cycles of freeze after ack
  task automatic txn(input logic mem, input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] rs2, input logic [31:0] rd, input int lat, input int hold);
    wb_t  r;
    logic mis;
    logic [31:0] inst;
    inst = $urandom;
    inst[14:12] = f3;
    @(negedge clk_i);
    alu_mem_i = addr; rs2_mem_i = rs2; pc4_mem_i = $urandom; MemRW_mem_i = rw;
    WBSel_mem_i = 2'($urandom_range(0, 3)); RegWEn_mem_i = 1'($urandom_range(0, 1));
    rsW_mem_i = 5'($urandom_range(0, 31)); inst_mem_i = inst; Valid_cpu2cache_mem_i = mem;
    enable_i = 1'b1; reset_i = 1'b0; ready_cache_i = 1'b0; rdata_cache_i = $urandom;
    r.alu = addr; r.pc4 = pc4_mem_i; r.inst = inst; r.wbsel = WBSel_mem_i;
    r.regwen = RegWEn_mem_i; r.rsw = rsW_mem_i; r.mem = 32'h0;
    mis = mem && ref_misaligned(f3, addr);
    if (!mem || mis) begin
      #1;
      check("misalign", misalign_o, {31'd0, mis});
      check("valid_noreq", valid_cache_o, 32'd0);
      check("stall_noreq", stall_o, 32'd0);
      exp_q.push_back(r);
      exp_adv = 1'b1;
    end else begin
      for (int c = 0; c < lat; c++) begin
        if (c > 0) @(negedge clk_i);
        ready_cache_i = 1'b0; rdata_cache_i = $urandom; exp_adv = 1'b0;
        #1;
        req_checks(rw, f3, addr, rs2, 1'b1);
      end
      if (lat > 0) @(negedge clk_i);
      ready_cache_i = 1'b1; rdata_cache_i = rd; enable_i = (hold == 0);
      #1;
      check("misalign_ok", misalign_o, 32'd0);
      req_checks(rw, f3, addr, rs2, 1'b0);
      r.mem = ref_load(f3, addr, rd);
      if (hold == 0) exp_q.push_back(r);
      exp_adv = (hold == 0);
      for (int c = 1; c <= hold; c++) begin
        @(negedge clk_i);
        ready_cache_i = 1'b0; rdata_cache_i = $urandom; enable_i = (c == hold);
        #1;
        check("valid_done", valid_cache_o, 32'd0);
        check("stall_done", stall_o, 32'd0);
        if (c == hold) exp_q.push_back(r);
        exp_adv = (c == hold);
      end
    end
  endtask

  task automatic bubble();
    @(negedge clk_i);
    Valid_cpu2cache_mem_i = 1'b0; enable_i = 1'b0; reset_i = 1'b0; ready_cache_i = 1'b0;
    alu_mem_i = $urandom; exp_adv = 1'b0;
  endtask

  task automatic flush();
    wb_t z;
    z = '{default: '0};
    @(negedge clk_i);
    Valid_cpu2cache_mem_i = 1'b0; enable_i = 1'b1; reset_i = 1'b1; ready_cache_i = 1'b0;
    alu_mem_i = $urandom;
    exp_q.push_back(z);
    exp_adv = 1'b1;
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "_valid"}, valid_cache_o, 32'd0);
    check({tag, "_stall"}, stall_o, 32'd0);
    check({tag, "_misalign"}, misalign_o, 32'd0);
    check({tag, "_alu_wb"}, alu_wb_o, 32'd0);
    check({tag, "_mem_wb"}, mem_wb_o, 32'd0);
    check({tag, "_pc4_wb"}, pc4_wb_o, 32'd0);
    check({tag, "_inst_wb"}, inst_wb_o, 32'd0);
    check({tag, "_wbsel"}, WBSel_wb_o, 32'd0);
    check({tag, "_regwen"}, RegWEn_wb_o, 32'd0);
    check({tag, "_rsw"}, rsW_wb_o, 32'd0);
  endtask

  // Monitor: pops on every edge the bench expects MEM/WB to advance, else expects a hold
  initial begin
    wb_t  last;
    logic adv;
    last = '{default: '0};
    forever begin
      @(posedge clk_i);
      adv = exp_adv;
      #1;
      if (rst_i) begin
        last = '{default: '0};
      end else if (adv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: advance with no expected entry at %0t", $time);
        end else begin
          last = exp_q.pop_front();
        end
      end
      check("alu_wb", alu_wb_o, last.alu);
      check("mem_wb", mem_wb_o, last.mem);
      check("pc4_wb", pc4_wb_o, last.pc4);
      check("inst_wb", inst_wb_o, last.inst);
      check("wbsel_wb", WBSel_wb_o, {30'd0, last.wbsel});
      check("regwen_wb", RegWEn_wb_o, {31'd0, last.regwen});
      check("rsw_wb", rsW_wb_o, {27'd0, last.rsw});
    end
  end

  initial begin
    logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    int sel;
    logic rw;
    rst_i = 1'b1; alu_mem_i = '0; rs2_mem_i = '0; pc4_mem_i = '0; inst_mem_i = '0;
    rdata_cache_i = '0; MemRW_mem_i = 1'b0; RegWEn_mem_i = 1'b0; Valid_cpu2cache_mem_i = 1'b0;
    enable_i = 1'b0; reset_i = 1'b0; ready_cache_i = 1'b0; WBSel_mem_i = '0; rsW_mem_i = '0;
    #2;
    zero_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    txn(1'b1, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
    txn(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_1234, 3, 0);
    txn(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h8001_1234, 3, 0);
    txn(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 2);
    txn(1'b1, 1'b0, 3'd4, 32'h0000_0201, 32'h0, 32'h1234_F056, 0, 1);
    txn(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h1111_2222, 0, 0);
    txn(1'b0, 1'b0, 3'd0, 32'h0000_0055, 32'h0, 32'h0, 0, 0);

    // Reset pulse in the middle of a miss
    @(negedge clk_i);
    alu_mem_i = 32'h0000_0300; inst_mem_i = 32'h0000_2003; MemRW_mem_i = 1'b0;
    Valid_cpu2cache_mem_i = 1'b1; enable_i = 1'b1; reset_i = 1'b0; ready_cache_i = 1'b0;
    exp_adv = 1'b0;
    #1;
    check("wait_stall_a", stall_o, 32'd1);
    @(negedge clk_i);
    #1;
    check("wait_stall_b", stall_o, 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    zero_outputs("midwait_rst");
    @(negedge clk_i);
    rst_i = 1'b0; Valid_cpu2cache_mem_i = 1'b0; enable_i = 1'b0;

    txn(1'b1, 1'b0, 3'd0, 32'h0000_0402, 32'h0, 32'h0080_0000, 0, 0);
    flush();
    txn(1'b0, 1'b0, 3'd0, 32'h0000_0077, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        flush();
      end else if (sel == 1) begin
        bubble();
      end else if (sel == 2) begin
        txn(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 32'h0, 0, 0);
      end else begin
        rw = ($urandom_range(0, 2) == 0);
        if (rw)
          txn(1'b1, 1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, 32'h0,
              $urandom_range(0, 4), $urandom_range(0, 2));
        else
          txn(1'b1, 1'b0, ld_f3[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(0, 2));
      end
    end

    bubble();
    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: %0d entries never observed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I five-stage pipeline, between the EX/MEM register and writeback. Takes the registered ALU result, store data and control from EX, runs a valid/ready transaction to the data cache, aligns store data and sign/zero-extends load data, and holds the MEM/WB pipeline register. It raises a stall while a cache access is outstanding and buffers returned data if the pipeline is frozen after the cache acknowledges.

## Interface
Parameters: none; widths are fixed by RV32I.

Ports:
- clk_i  in  1  clock. One clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- alu_mem_i  in  32  effective address, or ALU result for non-memory instructions.
- rs2_mem_i  in  32  raw store data.
- pc4_mem_i  in  32  PC+4 of the instruction.
- MemRW_mem_i  in  1  1 = store, 0 = load.
- WBSel_mem_i  in  2  writeback-select code, passed through unchanged.
- RegWEn_mem_i  in  1  register write enable.
- rsW_mem_i  in  5  destination register.
- inst_mem_i  in  32  instruction; funct3 = inst_mem_i[14:12].
- Valid_cpu2cache_mem_i  in  1  instruction is a load or store.
- enable_i  in  1  MEM/WB register advance enable, from the hazard unit.
- reset_i  in  1  synchronous flush of MEM/WB, qualified by enable_i.
- addr_cache_o  out  32  cache address = alu_mem_i.
- wdata_cache_o  out  32  lane-aligned store data.
- be_cache_o  out  4  byte enables.
- rw_cache_o  out  1  1 = write.
- valid_cache_o  out  1  request valid.
- ready_cache_i  in  1  one-cycle acknowledge; rdata is valid in that cycle.
- rdata_cache_i  in  32  read word.
- stall_o  out  1  freeze upstream stages and this stage.
- misalign_o  out  1  misaligned access flag, combinational.
- alu_wb_o, mem_wb_o, pc4_wb_o  out  32 each  registered ALU result, extended load data, PC+4.
- WBSel_wb_o  out  2; RegWEn_wb_o  out  1; rsW_wb_o  out  5; inst_wb_o  out  32  registered pass-through fields.

## Operation
FSM states and transitions:
- IDLE
  - valid_cache_o = Valid_cpu2cache_mem_i & ~misalign_o & (state == IDLE).
  - request and ready_cache_i: capture the extended load data and go to DONE, unless enable_i is high this cycle, in which case stay in IDLE.
  - request and no ready: go to WAIT.
- WAIT
  - valid_cache_o is held high; address, data, byte enables and rw stay stable.
  - ready_cache_i: capture data; go to IDLE if enable_i is high, else DONE.
- DONE
  - valid_cache_o is low, so the access is not re-issued.
  - The buffered data feeds mem_wb_o on the next enabled edge.
  - Go to IDLE when enable_i is high.
- stall_o = valid_cache_o & ~ready_cache_i.

Store alignment, with off = alu_mem_i[1:0]:
- SB: byte replicated to all four lanes, be = 4'b0001 << off.
- SH: halfword replicated to both halves, be = 4'b0011 << {off[1],1'b0}.
- SW: word unchanged, be = 4'b1111.
- Loads drive be = 4'b1111.

Load extraction selects the byte or halfword at off:
- LB (000) sign-extends a byte; LBU (100) zero-extends a byte.
- LH (001) sign-extends a halfword; LHU (101) zero-extends a halfword.
- LW (010) passes the word through.
- Any other funct3 gives 0.

Misalignment:
- misalign_o = valid & ((halfword & off[0]) | (word & |off)).
- The request is suppressed and the load result is 0.

Flush and freeze:
- enable_i & reset_i: all MEM/WB fields clear to 0 and the FSM returns to IDLE.
- enable_i low: MEM/WB holds its value.

## Timing
- rst_i: FSM goes to IDLE. Every registered output and the data buffer go to 0. valid_cache_o, stall_o and misalign_o go to 0. An abandoned request in WAIT is dropped, and the cache must tolerate this.
- Hit (ready in the request cycle): zero stall, and the result appears on mem_wb_o after the next edge.
- Miss with N cycles until ready: stall_o is high for N cycles, and mem_wb_o updates on the edge where ready is sampled.
- Non-memory instructions: one-cycle latency; alu_wb_o is registered at the enabled edge.
- The hazard unit never asserts reset_i while stall_o is high. In WAIT, reset_i is ignored.

## Structure
- Shared package rv32i_pkg holds:
  - funct3 load/store constants;
  - WBSel encodings;
  - the mem_state_e enum {IDLE, WAIT, DONE}.
- One combinational sub-module, lsu_align, holds store lane/byte-enable generation and load extraction. mem_stage contains the FSM, the data buffer and the MEM/WB register.

## Test plan
- SB to 0x103 with rs2 = 0x000000A5 and ready in the same cycle -> wdata = 0xA5A5A5A5, be = 4'b1000, stall_o stays 0.
- LH at 0x102 with rdata = 0x8001_1234 and ready after 3 cycles -> stall_o high for 3 cycles, mem_wb_o = 0xFFFF8001; LHU gives 0x00008001.
- Ready arrives while enable_i = 0 -> FSM enters DONE, valid_cache_o drops to 0 with no reissue; when enable_i = 1, mem_wb_o takes the buffered value and the FSM returns to IDLE.
- LW at 0x102 -> misalign_o = 1, valid_cache_o = 0, mem_wb_o = 0 after the edge.
- rst_i pulsed mid-WAIT -> all outputs 0 immediately, FSM in IDLE; enable_i & reset_i in IDLE -> MEM/WB fields cleared.
- ADD result 0x55 with Valid_cpu2cache_mem_i = 0 -> no request, alu_wb_o = 0x55 one cycle later.
